// File: rtl/error_detect_buffered_if.sv
// Flit channels of error_detect_buffered: parity-protected input, checked payload output
// and per-flit error records. All three use valid/ready handshakes.
interface error_detect_buffered_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W:0]   in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              err_flag;
  logic              err_valid;
  logic              err_ready;

  modport master (
    output in_data, in_valid, out_ready, err_ready,
    input  in_ready, out_data, out_valid, err_flag, err_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready, err_ready,
    output in_ready, out_data, out_valid, err_flag, err_valid
  );
endinterface

// File: rtl/error_detect_buffered.sv
// Buffered parity checker between link receiver and router core: input FIFO, check stage,
// output and error-record FIFOs, saturating error counter. Optional macro ERR_CAPTURE_EN.
module error_detect_buffered #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 4,
  parameter int ERR_DEPTH  = 4,
  parameter int DROP_BAD   = 0,
  parameter int PARITY_ODD = 0,
  parameter int CNT_W      = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  error_detect_buffered_if.slave bus,
  input  logic                   clr_count,
  output logic [CNT_W-1:0]       err_count
`ifdef ERR_CAPTURE_EN
  ,
  output logic [DATA_W:0]        err_first,
  output logic                   err_seen
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = $clog2(ERR_DEPTH);
  localparam logic [AW:0]      PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [EW:0]      EPTR_ONE = {{EW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [DATA_W:0]   in_mem  [DEPTH];
  logic [DATA_W-1:0] out_mem [DEPTH];
  logic              err_mem [ERR_DEPTH];

  logic [AW:0] in_wr, in_rd, out_wr, out_rd;
  logic [EW:0] err_wr, err_rd;

  logic in_full, in_empty, in_push, in_pop;
  logic out_full, out_empty, out_push, out_pop;
  logic err_full, err_empty, err_push, err_pop;
  logic [DATA_W:0] head;
  logic bad, drop, fire, bad_check;

  // Wrap bit differs and index matches -> full; identical pointers -> empty.
  assign in_full   = (in_wr[AW] != in_rd[AW]) && (in_wr[AW-1:0] == in_rd[AW-1:0]);
  assign in_empty  = (in_wr == in_rd);
  assign out_full  = (out_wr[AW] != out_rd[AW]) && (out_wr[AW-1:0] == out_rd[AW-1:0]);
  assign out_empty = (out_wr == out_rd);
  assign err_full  = (err_wr[EW] != err_rd[EW]) && (err_wr[EW-1:0] == err_rd[EW-1:0]);
  assign err_empty = (err_wr == err_rd);

  // NOTE: in_ready depends only on occupancy and RESET, never on downstream ready signals.
  assign bus.in_ready = !in_full && !RESET;
  assign in_push      = bus.in_valid && bus.in_ready;

  // Check stage: a bad flit that will be dropped needs no room in the output FIFO.
  assign head      = in_mem[in_rd[AW-1:0]];
  assign bad       = (^head) != (PARITY_ODD != 0);
  assign drop      = bad && (DROP_BAD != 0);
  assign fire      = !in_empty && !err_full && (!out_full || drop);
  assign bad_check = fire && bad;
  assign in_pop    = fire;
  assign out_push  = fire && !drop;
  assign err_push  = fire;

  assign bus.out_valid = !out_empty;
  assign bus.err_valid = !err_empty;
  assign out_pop       = bus.out_valid && bus.out_ready;
  assign err_pop       = bus.err_valid && bus.err_ready;
  assign bus.out_data  = bus.out_valid ? out_mem[out_rd[AW-1:0]] : '0;
  assign bus.err_flag  = bus.err_valid ? err_mem[err_rd[EW-1:0]] : 1'b0;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      in_wr  <= '0;
      in_rd  <= '0;
      out_wr <= '0;
      out_rd <= '0;
      err_wr <= '0;
      err_rd <= '0;
    end else begin
      if (in_push)  in_wr  <= in_wr  + PTR_ONE;
      if (in_pop)   in_rd  <= in_rd  + PTR_ONE;
      if (out_push) out_wr <= out_wr + PTR_ONE;
      if (out_pop)  out_rd <= out_rd + PTR_ONE;
      if (err_push) err_wr <= err_wr + EPTR_ONE;
      if (err_pop)  err_rd <= err_rd + EPTR_ONE;
    end
  end

  // NOTE: storage arrays are not reset; the pointers alone define valid contents and
  // the read ports present zero while a FIFO is empty.
  always_ff @(posedge CLK) begin
    if (in_push)  in_mem[in_wr[AW-1:0]]   <= bus.in_data;
    if (out_push) out_mem[out_wr[AW-1:0]] <= head[DATA_W-1:0];
    if (err_push) err_mem[err_wr[EW-1:0]] <= bad;
  end

  // Clear wins, but a bad check in the clearing cycle still counts.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      err_count <= '0;
    end else if (clr_count) begin
      err_count <= bad_check ? CNT_ONE : '0;
    end else if (bad_check && (err_count != CNT_MAX)) begin
      err_count <= err_count + CNT_ONE;
    end
  end

`ifdef ERR_CAPTURE_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      err_first <= '0;
      err_seen  <= 1'b0;
    end else if (clr_count) begin
      err_first <= bad_check ? head : '0;
      err_seen  <= bad_check;
    end else if (bad_check && !err_seen) begin
      err_first <= head;
      err_seen  <= 1'b1;
    end
  end
`endif
endmodule
